dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder on the CPU data-memory bus (DM_CS/DM_R/DM_W, addr, wdata, rdata). Sits beside dmem.
- Decodes a small address window and exposes a timer with compare interrupt plus an 8-entry mailbox FIFO.
- Read data is combinational, so the single-cycle CPU sees it in the same cycle. Writes and FIFO pops commit on the rising clock edge.
- Outside its window it drives rdata = 0, so the top level can OR its rdata with dmem's.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; must be aligned to 2^WIN_BITS.
- WIN_BITS, 6, window size in bytes = 2^WIN_BITS; decode compares addr[31:WIN_BITS].
- FIFO_DEPTH, 8, mailbox entries; power of two, 2..16.

Ports:
- clk_in  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk_in).
- DM_CS  in  1  bus chip select.
- DM_R  in  1  read strobe.
- DM_W  in  1  write strobe.
- addr  in  32  byte address; word access only, addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data; 0 when not selected.
- hit  out  1  DM_CS & window match; top uses it to suppress dmem.
- irq  out  1  interrupt = STATUS.PEND & CTRL.IE.

Behaviour:
- Access decoding:
  - sel = DM_CS & (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]).
  - rd = sel & DM_R & ~DM_W; wr = sel & DM_W (write wins if both strobes are high).
  - Register offset = addr[WIN_BITS-1:2].
- Register map (byte offsets):
  - 0x00 CTRL (RW): bit0 TEN timer enable, bit1 IE irq enable, bit2 AR auto-reload; other bits read 0.
  - 0x04 STATUS:
    - bit0 PEND, write-1-to-clear.
    - bit1 EMPTY (RO), bit2 FULL (RO).
    - bit3 OVF sticky, write-1-to-clear.
    - bits[8:4] fill count (RO).
  - 0x08 COUNT (RW), 32 bit.
  - 0x0C COMPARE (RW), 32 bit.
  - 0x10 FIFO (W pushes wdata; R returns head and pops at the clock edge).
  - Other offsets: read 0, writes ignored.
- Timer:
  - When TEN=1, COUNT increments by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0.
  - When COUNT == COMPARE and TEN=1, PEND is set on the next edge.
  - If AR=1, COUNT loads 0 on that same edge instead of incrementing.
  - A bus write to COUNT overrides the increment and reload in that cycle.
  - If a W1C write to PEND coincides with a new match, set wins: PEND stays 1.
- FIFO:
  - Circular buffer with head/tail pointers and a count 0..FIFO_DEPTH.
  - Push when full: data dropped, OVF set, pointers unchanged.
  - Read when empty: rdata = 0, no pop, no flag.
  - A read of FIFO pops exactly once per cycle in which rd is asserted for that offset.
  - A simultaneous push and pop cannot occur (one access per cycle).
- Reset (reset=0 at an edge):
  - CTRL = 0, COUNT = 0, COMPARE = 32'hFFFF_FFFF.
  - PEND = 0, OVF = 0; FIFO pointers and count = 0.
  - Hence irq = 0, rdata = 0 when not selected, EMPTY = 1.
  - FIFO storage contents are not reset.
  - Reset mid-operation discards all FIFO contents and any pending interrupt that cycle.
- Latency:
  - Read data: 0 cycles (combinational from the registered state).
  - Write effect: visible on the cycle after the edge.
  - irq: asserts the cycle after the match edge.

Optional Feature:
- Macro: MMIO_PRESCALER_EN.
- Defined:
  - Adds PRESCALE (RW, 16 bit) at offset 0x14; reset value 0.
  - The timer increments only on a tick, generated each PRESCALE+1 cycles by an internal 16-bit divider.
  - The divider clears on reset, when TEN=0, and on any write to PRESCALE.
  - Compare/reload is evaluated only on tick cycles.
- Not defined:
  - Offset 0x14 reads 0 and writes are ignored.
  - The timer ticks every cycle.

Test Plan:
- Reset behaviour: hold reset=0 for 2 cycles, then read 0x04 -> 32'h0000_0002 (EMPTY only); read 0x0C -> 32'hFFFF_FFFF; irq = 0.
- Timer match with auto-reload: write COMPARE=5, CTRL=3'b111 -> PEND and irq rise on the 6th edge after enable; COUNT reads 0 on the next cycle. Write STATUS=1 -> irq drops the next cycle.
- FIFO order and empty read: push 8 words 0x10..0x17 -> STATUS.FULL=1, count=8. A 9th push of 0xAA -> OVF=1 and is dropped. Eight reads return 0x10..0x17 in order; a 9th read returns 0 and EMPTY=1.
- Window decode and strobe priority:
  - DM_CS=0, or an address outside the window -> rdata = 0, hit = 0, no state change.
  - DM_R=DM_W=1 on FIFO -> push only, no pop.
- Set-wins collision and reset mid-operation:
  - A W1C of PEND in the same cycle as a match -> PEND remains 1.
  - Reset asserted with 3 FIFO entries and irq=1 -> next cycle count=0 and irq=0.
- MMIO_PRESCALER_EN: PRESCALE=3, COMPARE=2, TEN=1 -> PEND sets after 12 cycles. Without the macro, a read of 0x14 -> 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: MMIO responder on the CPU data-memory bus.
// Decodes a 2^WIN_BITS-byte window at BASE_ADDR and exposes a timer with
// compare interrupt plus a FIFO_DEPTH-entry mailbox FIFO.
// Read data is combinational from registered state. Writes and FIFO pops
// commit on the rising edge of clk_in.
// Optional build macro MMIO_PRESCALER_EN adds a 16-bit PRESCALE register
// at offset 0x14. It divides the timer tick.
module dmem_mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned WIN_BITS   = 6,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam int unsigned OFF_W = WIN_BITS - 2;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [OFF_W-1:0] OFF_CTRL    = OFF_W'(3'd0);
    localparam logic [OFF_W-1:0] OFF_STATUS  = OFF_W'(3'd1);
    localparam logic [OFF_W-1:0] OFF_COUNT   = OFF_W'(3'd2);
    localparam logic [OFF_W-1:0] OFF_COMPARE = OFF_W'(3'd3);
    localparam logic [OFF_W-1:0] OFF_FIFO    = OFF_W'(3'd4);
`ifdef MMIO_PRESCALER_EN
    localparam logic [OFF_W-1:0] OFF_PRESC   = OFF_W'(3'd5);
`endif

    // Bus decode
    logic             sel_s;
    logic             rd_s;
    logic             wr_s;
    logic [OFF_W-1:0] off_s;

    // Per-register strobes
    logic wr_ctrl_s;
    logic wr_status_s;
    logic wr_count_s;
    logic wr_compare_s;
    logic push_s;
    logic pop_s;
    logic wr_presc_s;

    // Control / timer state
    logic        ten_r;
    logic        ie_r;
    logic        ar_r;
    logic        pend_r;
    logic        ovf_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        tick_s;
    logic        match_s;

    // Mailbox FIFO state
    logic [31:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] fill_r;
    logic             empty_s;
    logic             full_s;

    logic [31:0] rdata_s;

    // The address is word-granular, so the byte-lane bits carry no meaning.
    logic unused_s;
    assign unused_s = ^addr[1:0];

    assign sel_s   = DM_CS & (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign rd_s    = sel_s & DM_R & ~DM_W;
    assign wr_s    = sel_s & DM_W;
    assign off_s   = addr[WIN_BITS-1:2];
    assign empty_s = (fill_r == {CNT_W{1'b0}});
    assign full_s  = (fill_r == CNT_W'(FIFO_DEPTH));
    assign match_s = tick_s & (count_r == compare_r);

    // Turn the decoded offset into one strobe per register.
    always_comb begin
        wr_ctrl_s    = 1'b0;
        wr_status_s  = 1'b0;
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        wr_presc_s   = 1'b0;
        case (off_s)
            OFF_CTRL:    wr_ctrl_s    = wr_s;
            OFF_STATUS:  wr_status_s  = wr_s;
            OFF_COUNT:   wr_count_s   = wr_s;
            OFF_COMPARE: wr_compare_s = wr_s;
            OFF_FIFO: begin
                push_s = wr_s;
                pop_s  = rd_s & ~empty_s;
            end
`ifdef MMIO_PRESCALER_EN
            OFF_PRESC:   wr_presc_s   = wr_s;
`endif
            default:     wr_ctrl_s    = 1'b0;
        endcase
    end

`ifdef MMIO_PRESCALER_EN
    logic [15:0] presc_r;
    logic [15:0] div_r;

    assign tick_s = ten_r & (div_r == presc_r);

    // Divider: counts 0..PRESCALE. It restarts when the timer is off or the
    // divisor is rewritten, so a new divisor takes effect from a clean phase.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            presc_r <= 16'd0;
            div_r   <= 16'd0;
        end else begin
            if (wr_presc_s) begin
                presc_r <= wdata[15:0];
            end
            if (!ten_r || wr_presc_s) begin
                div_r <= 16'd0;
            end else if (div_r == presc_r) begin
                div_r <= 16'd0;
            end else begin
                div_r <= div_r + 16'd1;
            end
        end
    end
`else
    assign tick_s = ten_r;
`endif

    // Control register, timer counter/compare, and the PEND flag. A new
    // match beats a simultaneous write-1-to-clear of PEND.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            ten_r     <= 1'b0;
            ie_r      <= 1'b0;
            ar_r      <= 1'b0;
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            pend_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                ten_r <= wdata[0];
                ie_r  <= wdata[1];
                ar_r  <= wdata[2];
            end
            if (wr_compare_s) begin
                compare_r <= wdata;
            end
            if (wr_count_s) begin
                count_r <= wdata;
            end else if (match_s && ar_r) begin
                count_r <= 32'd0;
            end else if (tick_s) begin
                count_r <= count_r + 32'd1;
            end
            if (match_s) begin
                pend_r <= 1'b1;
            end else if (wr_status_s && wdata[0]) begin
                pend_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, fill count, and the sticky overflow flag. A push into a
    // full FIFO is dropped and only sets OVF.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            fill_r <= {CNT_W{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            if (push_s) begin
                if (!full_s) begin
                    tail_r <= tail_r + PTR_W'(1'b1);
                    fill_r <= fill_r + CNT_W'(1'b1);
                end
            end else if (pop_s) begin
                head_r <= head_r + PTR_W'(1'b1);
                fill_r <= fill_r - CNT_W'(1'b1);
            end
            if (push_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && wdata[3]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FIFO storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (push_s && !full_s) begin
            mem_r[tail_r] <= wdata;
        end
    end

    // Combinational read mux. It returns zero outside the window so the top level can OR this with dmem.
    always_comb begin
        rdata_s = 32'd0;
        if (sel_s) begin
            case (off_s)
                OFF_CTRL:    rdata_s = {29'd0, ar_r, ie_r, ten_r};
                OFF_STATUS:  rdata_s = {23'd0, 5'(fill_r), ovf_r, full_s, empty_s, pend_r};
                OFF_COUNT:   rdata_s = count_r;
                OFF_COMPARE: rdata_s = compare_r;
                OFF_FIFO: begin
                    if (empty_s) begin
                        rdata_s = 32'd0;
                    end else begin
                        rdata_s = mem_r[head_r];
                    end
                end
`ifdef MMIO_PRESCALER_EN
                OFF_PRESC:   rdata_s = {16'd0, presc_r};
`endif
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata = rdata_s;
    assign hit   = sel_s;
    assign irq   = pend_r & ie_r;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder. It runs directed scenarios
// first and then randomized bus traffic. All outputs are compared against a
// behavioural register-map model that uses a queue for the mailbox.
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        DM_CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_ten, m_ie, m_ar, m_pend, m_ovf;
    logic [31:0] m_count, m_compare;
    logic [15:0] m_presc, m_div;
    logic [31:0] m_q[$];
    logic        model_valid = 1'b0;
    logic [31:0] last_rdata;

    dmem_mmio_responder dut (
        .clk_in(clk_in),
        .reset (reset),
        .DM_CS (DM_CS),
        .DM_R  (DM_R),
        .DM_W  (DM_W),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic model_sel(input logic cs, input logic [31:0] a);
        return cs && ((a >> 6) == (BASE >> 6));
    endfunction

    function automatic logic [31:0] model_rdata(input logic cs, input logic [31:0] a);
        int n;
        n = m_q.size();
        if (!model_sel(cs, a)) return 32'd0;
        case ((a % 64) / 4)
            0: return 32'(m_ten) + 32'(m_ie) * 2 + 32'(m_ar) * 4;
            1: return 32'(m_pend) + ((n == 0) ? 2 : 0) + ((n == DEPTH) ? 4 : 0)
                      + 32'(m_ovf) * 8 + 32'(n) * 16;
            2: return m_count;
            3: return m_compare;
            4: return (n > 0) ? m_q[0] : 32'd0;
`ifdef MMIO_PRESCALER_EN
            5: return 32'(m_presc);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic cs, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] wd);
        logic sel, rd, wr, tick, match;
        int   off;
        if (!rst) begin
            m_ten = 0; m_ie = 0; m_ar = 0; m_pend = 0; m_ovf = 0;
            m_count = 0; m_compare = 32'hFFFF_FFFF; m_presc = 0; m_div = 0;
            m_q.delete();
            return;
        end
        sel = model_sel(cs, a);
        rd  = sel && r && !w;
        wr  = sel && w;
        off = (a % 64) / 4;
`ifdef MMIO_PRESCALER_EN
        tick = m_ten && (m_div == m_presc);
        if (!m_ten || (wr && off == 5)) m_div = 0;
        else if (m_div == m_presc)       m_div = 0;
        else                             m_div = m_div + 1;
`else
        tick = m_ten;
`endif
        match = tick && (m_count == m_compare);
        if (wr && off == 2)       m_count = wd;
        else if (match && m_ar)   m_count = 0;
        else if (tick)            m_count = m_count + 1;
        if (match)                          m_pend = 1;
        else if (wr && off == 1 && wd[0])   m_pend = 0;
        if (wr && off == 4 && m_q.size() == DEPTH) m_ovf = 1;
        else if (wr && off == 1 && wd[3])          m_ovf = 0;
        if (wr && off == 4) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
        end else if (rd && off == 4 && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        if (wr && off == 0) begin m_ten = wd[0]; m_ie = wd[1]; m_ar = wd[2]; end
        if (wr && off == 3) m_compare = wd;
`ifdef MMIO_PRESCALER_EN
        if (wr && off == 5) m_presc = wd[15:0];
`endif
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, check at the falling
    // edge, then advance the model at the next rising edge.
    task automatic step(input logic rst, input logic cs, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_hit;
        reset = rst; DM_CS = cs; DM_R = r; DM_W = w; addr = a; wdata = wd;
        @(negedge clk_in);
        exp_rd     = model_rdata(cs, a);
        exp_hit    = model_sel(cs, a);
        last_rdata = rdata;
        if (model_valid) begin
            if (!exp_hit || (r && !w)) expect_val("rdata", rdata, exp_rd);
            expect_val("hit", 32'(hit), 32'(exp_hit));
            expect_val("irq", 32'(irq), 32'(m_pend & m_ie));
        end
        @(posedge clk_in);
        model_update(rst, cs, r, w, a, wd);
        if (!rst) model_valid = 1'b1;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d); step(1, 1, 0, 1, a, d); endtask
    task automatic rd(input logic [31:0] a); step(1, 1, 1, 0, a, 32'd0); endtask
    task automatic idle(); step(1, 0, 0, 0, 32'd0, 32'd0); endtask

    initial begin
        reset = 1'b0; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0; addr = 32'd0; wdata = 32'd0;
        @(posedge clk_in); #1;

        // Reset state
        step(0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 32'd0, 32'd0);
        rd(32'h1004); expect_val("reset_status", last_rdata, 32'h0000_0002);
        rd(32'h100C); expect_val("reset_compare", last_rdata, 32'hFFFF_FFFF);
        expect_val("reset_irq", 32'(irq), 32'd0);

        // Timer match with auto-reload
        wr(32'h100C, 32'd5);
        wr(32'h1000, 32'd7);
        repeat (5) idle();
        expect_val("irq_before_match", 32'(irq), 32'd0);
        idle();
        expect_val("irq_at_match", 32'(irq), 32'd1);
        rd(32'h1008); expect_val("count_reloaded", last_rdata, 32'd0);
        wr(32'h1004, 32'd1);
        expect_val("irq_after_w1c", 32'(irq), 32'd0);
        wr(32'h1000, 32'd0);

        // Set wins over a simultaneous W1C
        wr(32'h100C, 32'd10);
        wr(32'h1008, 32'd8);
        wr(32'h1000, 32'd3);
        idle(); idle();
        wr(32'h1004, 32'd1);
        expect_val("set_wins", 32'(irq), 32'd1);
        wr(32'h1000, 32'd0);
        wr(32'h1004, 32'd1);
        expect_val("irq_cleared", 32'(irq), 32'd0);

`ifdef MMIO_PRESCALER_EN
        // Prescaled timer
        wr(32'h1014, 32'd3);
        wr(32'h100C, 32'd2);
        wr(32'h1008, 32'd0);
        wr(32'h1000, 32'd3);
        repeat (11) idle();
        expect_val("presc_before", 32'(irq), 32'd0);
        idle();
        expect_val("presc_match", 32'(irq), 32'd1);
        wr(32'h1000, 32'd0);
        wr(32'h1004, 32'd1);
`else
        wr(32'h1014, 32'h0000_ABCD);
        rd(32'h1014); expect_val("presc_absent", last_rdata, 32'd0);
`endif

        // FIFO order, overflow, and empty read
        for (int i = 0; i < 8; i++) wr(32'h1010, 32'h10 + 32'(i));
        rd(32'h1004); expect_val("fifo_full", last_rdata, 32'h0000_0084);
        wr(32'h1010, 32'hAA);
        rd(32'h1004); expect_val("fifo_ovf", last_rdata, 32'h0000_008C);
        for (int i = 0; i < 8; i++) begin
            rd(32'h1010); expect_val("fifo_order", last_rdata, 32'h10 + 32'(i));
        end
        rd(32'h1010); expect_val("fifo_empty_read", last_rdata, 32'd0);
        rd(32'h1004); expect_val("fifo_empty_status", last_rdata, 32'h0000_000A);
        wr(32'h1004, 32'd8);

        // Window decode and strobe priority
        step(1, 0, 1, 0, 32'h1004, 32'd0);
        expect_val("cs_off_rdata", last_rdata, 32'd0);
        step(1, 1, 1, 0, 32'h2004, 32'd0);
        expect_val("outside_rdata", last_rdata, 32'd0);
        step(1, 0, 0, 1, 32'h1010, 32'h77);
        step(1, 1, 0, 1, 32'h2010, 32'h78);
        rd(32'h1004); expect_val("no_state_change", last_rdata, 32'h0000_0002);
        step(1, 1, 1, 1, 32'h1010, 32'h55);
        rd(32'h1004); expect_val("rw_push_only", last_rdata, 32'h0000_0010);
        rd(32'h1010); expect_val("rw_data", last_rdata, 32'h55);

        // Reset in the middle of operation
        wr(32'h1008, 32'd0);
        wr(32'h100C, 32'd1);
        wr(32'h1000, 32'd3);
        idle(); idle();
        for (int i = 0; i < 3; i++) wr(32'h1010, 32'hC0 + 32'(i));
        expect_val("pre_reset_irq", 32'(irq), 32'd1);
        rd(32'h1004); expect_val("pre_reset_status", last_rdata, 32'h0000_0031);
        step(0, 0, 0, 0, 32'd0, 32'd0);
        expect_val("post_reset_irq", 32'(irq), 32'd0);
        rd(32'h1004); expect_val("post_reset_status", last_rdata, 32'h0000_0002);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        rst_v, cs_v, r_v, w_v;
            logic [31:0] a_v, d_v;
            rst_v = ($urandom_range(0, 149) != 0);
            cs_v  = ($urandom_range(0, 9) != 0);
            r_v   = 1'($urandom_range(0, 1));
            w_v   = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) != 0)
                a_v = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            else
                a_v = $urandom;
            d_v = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
            step(rst_v, cs_v, r_v, w_v, a_v, d_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
